ysyx_22050518_mul_seq: RTL and testbench

Iterative 64-bit multiplier sequencer for the NPC execute stage. Drives one instance of `ysyx_22050518_add` once per cycle to compute RV64M MUL/MULH/MULHSU/MULHU/MULW by radix-2 shift-add on operand magnitudes, with sign correction. Every pass, including operand absolute value and final 128-bit negation, goes through the one shared adder. Latency is fixed and data-independent. Valid/ready on both sides, plus a pipeline flush.

---
 rtl/ysyx_22050518_mul_seq_if.sv | 25 ++
 rtl/ysyx_22050518_mul_seq.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_22050518_mul_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050518_mul_seq_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// The master issues operands and consumes results; the slave is the multiplier.
interface ysyx_22050518_mul_seq_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         word;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    modport master (
        output in_valid, op, word, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, word, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_22050518_mul_seq.sv
// Radix-2 shift-add RV64M multiplier. Every arithmetic pass (magnitudes,
// partial sums, final 128-bit negation) is routed through one shared adder.
module ysyx_22050518_add #(
    parameter int W = 64
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         c_in,
    output logic [W-1:0] out,
    output logic         c_out
);
    assign {c_out, out} = {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, c_in};
endmodule

module ysyx_22050518_mul_seq #(
    parameter int W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    ysyx_22050518_mul_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        ITER,
        NEG_LO,
        NEG_HI,
        DONE
    } state_t;

    state_t       state_reg;
    logic [1:0]   op_reg;
    logic         word_reg;
    logic         neg_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] mcand_reg;
    logic [W-1:0] acc_hi_reg;
    logic [W-1:0] acc_lo_reg;
    logic [5:0]   cnt_reg;
    logic         carry_reg;
    logic [W-1:0] result_reg;
    logic         out_valid_reg;

    logic [W-1:0] add_in1;
    logic [W-1:0] add_in2;
    logic         add_c_in;
    logic [W-1:0] add_out;
    logic         add_c_out;

    // Signedness of the latched operation and of the incoming request.
    logic s1_lat;
    logic s2_lat;
    logic s1_in;
    logic s2_in;
    logic word_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic inv_a;
    logic inv_b;

    assign s1_lat  = (op_reg != 2'b11);
    assign s2_lat  = (op_reg == 2'b00) || (op_reg == 2'b01);
    assign s1_in   = (bus.op != 2'b11);
    assign s2_in   = (bus.op == 2'b00) || (bus.op == 2'b01);
    // MULW is only meaningful for op=00; any other op runs as a full 64-bit op.
    assign word_in = bus.word && (bus.op == 2'b00);
    assign a_in    = word_in ? {{(W-32){bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
    assign b_in    = word_in ? {{(W-32){bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
    assign inv_a   = s1_lat && a_reg[W-1];
    assign inv_b   = s2_lat && b_reg[W-1];

    ysyx_22050518_add #(.W(W)) u_add (
        .in1   (add_in1),
        .in2   (add_in2),
        .c_in  (add_c_in),
        .out   (add_out),
        .c_out (add_c_out)
    );

    always_comb begin
        add_in1  = '0;
        add_in2  = '0;
        add_c_in = 1'b0;
        case (state_reg)
            ABS_A: begin
                add_in1  = inv_a ? ~a_reg : a_reg;
                add_c_in = inv_a;
            end
            ABS_B: begin
                add_in1  = inv_b ? ~b_reg : b_reg;
                add_c_in = inv_b;
            end
            ITER: begin
                add_in1 = acc_hi_reg;
                add_in2 = acc_lo_reg[0] ? mcand_reg : '0;
            end
            NEG_LO: begin
                add_in1  = neg_reg ? ~acc_lo_reg : acc_lo_reg;
                add_c_in = neg_reg;
            end
            NEG_HI: begin
                add_in1  = neg_reg ? ~acc_hi_reg : acc_hi_reg;
                add_c_in = neg_reg && carry_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            word_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            mcand_reg     <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg    <= bus.op;
                        word_reg  <= word_in;
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        neg_reg   <= (s1_in && a_in[W-1]) ^ (s2_in && b_in[W-1]);
                        state_reg <= ABS_A;
                    end
                end
                ABS_A: begin
                    mcand_reg <= add_out;
                    state_reg <= ABS_B;
                end
                ABS_B: begin
                    acc_lo_reg <= add_out;
                    acc_hi_reg <= '0;
                    cnt_reg    <= '0;
                    state_reg  <= ITER;
                end
                ITER: begin
                    // Shift the 129-bit {carry, sum, acc_lo} right by one.
                    acc_hi_reg <= {add_c_out, add_out[W-1:1]};
                    acc_lo_reg <= {add_out[0], acc_lo_reg[W-1:1]};
                    cnt_reg    <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'd63) begin
                        state_reg <= NEG_LO;
                    end
                end
                NEG_LO: begin
                    acc_lo_reg <= add_out;
                    carry_reg  <= add_c_out;
                    state_reg  <= NEG_HI;
                end
                NEG_HI: begin
                    acc_hi_reg <= add_out;
                    if (word_reg) begin
                        result_reg <= {{(W-32){acc_lo_reg[31]}}, acc_lo_reg[31:0]};
                    end else if (op_reg == 2'b00) begin
                        result_reg <= acc_lo_reg;
                    end else begin
                        result_reg <= add_out;
                    end
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
endmodule

// File: tb/tb_ysyx_22050518_mul_seq.sv
// Directed bench for the iterative multiplier: latency, op variants,
// backpressure, flush and mid-operation reset.
module tb_ysyx_22050518_mul_seq;
    logic clk;
    logic rst;
    logic flush;
    int   errors;
    int   checks;

    ysyx_22050518_mul_seq_if #(.W(64)) bus ();

    ysyx_22050518_mul_seq #(.W(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and count cycles from the accept edge to out_valid.
    task automatic launch(input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        bus.op = op; bus.word = word; bus.src1 = a; bus.src2 = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        checks++;
        if (bus.result !== 64'd0) begin
            errors++; $display("FAIL reset_result got=%h want=0", bus.result);
        end
    endtask

    task automatic test_ops();
        logic [1:0]  t_op   [8];
        logic        t_word [8];
        logic [63:0] t_a    [8];
        logic [63:0] t_b    [8];
        logic [63:0] t_exp  [8];
        int lat;
        t_op[0]=2'b00; t_word[0]=0; t_a[0]=64'd3;                  t_b[0]=64'd5;                  t_exp[0]=64'h000000000000000F;
        t_op[1]=2'b00; t_word[1]=0; t_a[1]=64'hFFFFFFFFFFFFFFFD;   t_b[1]=64'd5;                  t_exp[1]=64'hFFFFFFFFFFFFFFF1;
        t_op[2]=2'b01; t_word[2]=0; t_a[2]=64'h8000000000000000;   t_b[2]=64'h8000000000000000;   t_exp[2]=64'h4000000000000000;
        t_op[3]=2'b11; t_word[3]=0; t_a[3]=64'hFFFFFFFFFFFFFFFF;   t_b[3]=64'hFFFFFFFFFFFFFFFF;   t_exp[3]=64'hFFFFFFFFFFFFFFFE;
        t_op[4]=2'b10; t_word[4]=0; t_a[4]=64'hFFFFFFFFFFFFFFFF;   t_b[4]=64'hFFFFFFFFFFFFFFFF;   t_exp[4]=64'hFFFFFFFFFFFFFFFF;
        t_op[5]=2'b01; t_word[5]=0; t_a[5]=64'hFFFFFFFFFFFFFFFF;   t_b[5]=64'hFFFFFFFFFFFFFFFF;   t_exp[5]=64'h0000000000000000;
        t_op[6]=2'b00; t_word[6]=1; t_a[6]=64'h123456787FFFFFFF;   t_b[6]=64'd2;                  t_exp[6]=64'hFFFFFFFFFFFFFFFE;
        // word is ignored for MULHU: (2^32+1)*(2^32) high half = 1
        t_op[7]=2'b11; t_word[7]=1; t_a[7]=64'h0000000100000001;   t_b[7]=64'h0000000100000000;   t_exp[7]=64'h0000000000000001;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            launch(t_op[i], t_word[i], t_a[i], t_b[i], lat);
            checks++;
            if (lat != 68) begin
                errors++; $display("FAIL op%0d_latency got=%0d want=68", i, lat);
            end
            checks++;
            if (bus.result !== t_exp[i]) begin
                errors++; $display("FAIL op%0d_result got=%h want=%h", i, bus.result, t_exp[i]);
            end
            $display("op%0d op=%0d word=%0d a=%h b=%h result=%h lat=%0d", i, t_op[i], t_word[i], t_a[i], t_b[i], bus.result, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_res;
        int bad_rdy;
        bad_res = 0; bad_rdy = 0;
        bus.out_ready = 1'b0;
        launch(2'b00, 1'b0, 64'd7, 64'd9, lat);
        checks++;
        if (lat != 68 || bus.result !== 64'd63) begin
            errors++; $display("FAIL bp_first got lat=%0d res=%h want lat=68 res=3f", lat, bus.result);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.src1 = 64'd1; bus.src2 = 64'd1;
            @(posedge clk); #1;
            if (bus.result !== 64'd63 || bus.out_valid !== 1'b1) bad_res++;
            if (bus.in_ready !== 1'b0) bad_rdy++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_res != 0) begin
            errors++; $display("FAIL bp_hold bad_cycles=%0d want=0", bad_res);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++; $display("FAIL bp_in_ready bad_cycles=%0d want=0", bad_rdy);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        $display("backpressure result=%h", bus.result);
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        bus.out_ready = 1'b1;
        bus.op = 2'b00; bus.word = 1'b0; bus.src1 = 64'd11; bus.src2 = 64'd13;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Two setup cycles then 29 ITER cycles; the next cycle is the 30th.
        repeat (31) @(posedge clk);
        #1;
        flush = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.result !== 64'd63) begin
            errors++; $display("FAIL flush_result_kept got=%h want=3f", bus.result);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_no_valid got valid_cycles=%0d in_ready=%b want 0 1", seen, bus.in_ready);
        end
        launch(2'b11, 1'b0, 64'h10, 64'h10, lat);
        checks++;
        if (lat != 68 || bus.result !== 64'd0) begin
            errors++; $display("FAIL flush_next got lat=%0d res=%h want lat=68 res=0", lat, bus.result);
        end
        $display("flush then mulhu result=%h lat=%0d", bus.result, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.out_ready = 1'b1;
        bus.op = 2'b00; bus.word = 1'b0; bus.src1 = 64'd100; bus.src2 = 64'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0) begin
            errors++; $display("FAIL rst_mid got in_ready=%b out_valid=%b res=%h want 1 0 0", bus.in_ready, bus.out_valid, bus.result);
        end
        launch(2'b00, 1'b0, 64'd100, 64'd3, lat);
        checks++;
        if (lat != 68 || bus.result !== 64'd300) begin
            errors++; $display("FAIL rst_recover got lat=%0d res=%h want lat=68 res=12c", lat, bus.result);
        end
        $display("reset recovery result=%h lat=%0d", bus.result, lat);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.word = 1'b0;
        bus.src1 = '0; bus.src2 = '0; bus.out_ready = 1'b1;
        test_reset();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
